uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter among NUM_REQ byte-stream requesters.
- Arbitrates round-robin and holds the grant for a whole packet until the requester marks its last byte.
- Sequences the transmitter's start/ready handshake, one byte at a time.
- Sits between client logic and the UART TX datapath (start pulse in, serial line out, ready back).

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ACK_TIMEOUT, 4, max cycles after o_tx_start for i_tx_ready to drop before a launch is declared failed.

Ports:
- i_clk  input  1  system clock, all logic on rising edge.
- i_rst  input  1  asynchronous reset, active-high.
- i_req_valid  input  NUM_REQ  per-requester byte available; held with data until accepted.
- i_req_data  input  8*NUM_REQ  byte of requester k at bits [8k+7:8k].
- i_req_last  input  NUM_REQ  byte is the last of its packet.
- o_req_ready  output  NUM_REQ  one-hot single-cycle accept pulse to the requester whose byte was taken.
- o_grant  output  NUM_REQ  one-hot current owner; all-zero when unowned.
- o_tx_data  output  8  byte to the transmitter, registered, stable from launch until the next launch.
- o_tx_start  output  1  single-cycle transmit strobe.
- i_tx_ready  input  1  transmitter idle (high) / shifting (low).
- o_busy  output  1  high in any state other than IDLE.
- o_err_timeout  output  1  sticky; set when the ACK_TIMEOUT window expires; cleared only by reset.

Behaviour:
- Reset, asynchronous, any state:
  - All outputs go to 0.
  - State goes to IDLE.
  - Round-robin pointer goes to 0 (requester 0 has highest priority first).
  - Locked owner is cleared.
  - A byte in flight is abandoned. The transmitter is not notified.
- States: IDLE, LAUNCH, WAIT_ACK, WAIT_DONE.
- IDLE:
  - If unlocked and any i_req_valid is set, pick the first valid requester at or after the pointer, wrapping modulo NUM_REQ.
  - If locked, consider only the owner's i_req_valid.
  - Leave IDLE only when a candidate exists and i_tx_ready=1.
  - On leaving: register o_tx_data, set o_grant, remember the last flag, go to LAUNCH.
- LAUNCH, exactly 1 cycle:
  - o_tx_start=1.
  - o_req_ready[owner]=1, so the byte is consumed here.
  - Go to WAIT_ACK with the timeout counter at 0.
- WAIT_ACK:
  - If i_tx_ready=0, go to WAIT_DONE.
  - Otherwise increment the counter. When it reaches ACK_TIMEOUT, set o_err_timeout and go to WAIT_DONE.
  - On timeout the byte counts as sent; there is no retry.
- WAIT_DONE: wait for i_tx_ready=1, then:
  - If last=1: clear the lock, set the pointer to (owner+1) mod NUM_REQ, set o_grant=0, go to IDLE.
  - If last=0: keep the lock and o_grant, go to IDLE.
- Latency: request sampled in IDLE at cycle N gives o_tx_start at cycle N+1.
- Consecutive bytes: minimum spacing is 3 cycles plus the transmitter busy time.
- A locked owner that drops i_req_valid stalls the arbiter indefinitely. Other requesters are not served. This is intentional packet atomicity.
- A requester changing data while valid and not yet accepted is a protocol violation; behaviour is unspecified.
- i_req_valid from non-owners during a packet is ignored; their ready stays 0.
- At most one o_req_ready bit is high per cycle, and only in LAUNCH.
- o_tx_start is never asserted while i_tx_ready=0.
- A requester asserting valid in the same cycle the previous packet's last byte completes is considered in the next IDLE cycle.

Test Plan:
- Single byte: req0 valid, data 8'h55, last=1, tx_ready=1. Required: o_tx_start pulses 1 cycle later with o_tx_data=8'h55 and o_req_ready=4'b0001. After tx_ready falls then rises, o_grant=0 and the pointer is 1.
- Round-robin: req0..req3 all valid, single-byte packets 8'hA0..8'hA3, pointer=0. Required: launch order 0,1,2,3. Then with req0 and req2 re-asserted, order 0,2.
- Packet lock: req1 sends 3 bytes 8'h11,8'h22,8'h33 (last on the third) while req2 is continuously valid. Required: bytes from req1 launch back-to-back in order, o_grant=4'b0010 throughout, and req2 launches only after 8'h33 completes.
- Owner stall: req0 sends byte 1 with last=0, then drops valid for 20 cycles while req3 is valid. Required: no o_tx_start, o_grant stays 4'b0001, and o_busy stays 0 in IDLE (an IDLE-state stall is not busy).
- Timeout: tx_ready held at 1 after launch. Required: o_err_timeout=1 exactly ACK_TIMEOUT (4) cycles after WAIT_ACK entry, and the arbiter proceeds to the next request.
- Reset mid-operation: assert i_rst in WAIT_DONE. Required: all outputs 0 in the same cycle, and the next grant goes to requester 0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares a single UART transmitter among NUM_REQ byte-stream requesters.
//   Requesters are chosen round-robin. Once chosen, a requester keeps the
//   transmitter until it sends a byte flagged as last. Each byte goes through
//   the transmitter's start/ready handshake before the next byte is taken.
//
// Requester handshake (valid/ready):
//   A requester raises i_req_valid[k] with i_req_data/i_req_last and holds all
//   three unchanged until it sees o_req_ready[k]. The byte is taken in the one
//   cycle in which o_req_ready[k] is high. The requester may then present its
//   next byte or drop valid. o_req_ready has at most one bit set, and only in
//   LAUNCH.
//
// Transmitter handshake:
//   o_tx_start pulses for one cycle with o_tx_data valid. The transmitter
//   drops i_tx_ready while it shifts and raises it again when it is idle.
//
// Ports:
//   i_clk, i_rst    clock; asynchronous active-high reset
//   i_req_valid     per-requester byte available
//   i_req_data      byte of requester k at [8k+7:8k]
//   i_req_last      byte is the last of its packet
//   o_req_ready     one-hot accept pulse
//   o_grant         one-hot current owner; zero when unowned
//   o_tx_data       byte to the transmitter, held from launch to next launch
//   o_tx_start      single-cycle transmit strobe
//   i_tx_ready      transmitter idle (1) / shifting (0)
//   o_busy          FSM not in IDLE
//   o_err_timeout   sticky: transmitter never acknowledged a launch
//   o_state         debug view of the FSM state (IDLE=0, LAUNCH=1,
//                   WAIT_ACK=2, WAIT_DONE=3)
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ACK_TIMEOUT = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [NUM_REQ-1:0]   i_req_valid,
  input  logic [8*NUM_REQ-1:0] i_req_data,
  input  logic [NUM_REQ-1:0]   i_req_last,
  output logic [NUM_REQ-1:0]   o_req_ready,
  output logic [NUM_REQ-1:0]   o_grant,
  output logic [7:0]           o_tx_data,
  output logic                 o_tx_start,
  input  logic                 i_tx_ready,
  output logic                 o_busy,
  output logic                 o_err_timeout,
  output logic [1:0]           o_state
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [IDX_W:0]     NUM_REQ_W = (IDX_W + 1)'(NUM_REQ);
  localparam logic [NUM_REQ-1:0] ONE_HOT0  = NUM_REQ'(1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_ACK  = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] owner;
  logic             locked;
  logic             last_flag;
  logic [CNT_W-1:0] cnt;

  // Candidate selection for IDLE. While a packet is open only the owner is
  // eligible; otherwise search from the pointer, wrapping modulo NUM_REQ.
  logic             found;
  logic [IDX_W-1:0] pick;
  logic [IDX_W:0]   cand;

  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    if (locked) begin
      found = i_req_valid[owner];
      pick  = owner;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        cand = {1'b0, ptr} + (IDX_W + 1)'(i);
        if (cand >= NUM_REQ_W) cand = cand - NUM_REQ_W;
        if (!found && i_req_valid[cand[IDX_W-1:0]]) begin
          found = 1'b1;
          pick  = cand[IDX_W-1:0];
        end
      end
    end
  end

  logic [IDX_W-1:0] next_ptr;
  assign next_ptr = (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + IDX_W'(1);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state         <= IDLE;
      ptr           <= '0;
      owner         <= '0;
      locked        <= 1'b0;
      last_flag     <= 1'b0;
      cnt           <= '0;
      o_grant       <= '0;
      o_req_ready   <= '0;
      o_tx_data     <= '0;
      o_tx_start    <= 1'b0;
      o_err_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // Launch only into an idle transmitter, so o_tx_start never
          // coincides with i_tx_ready low.
          if (found && i_tx_ready) begin
            o_tx_data   <= i_req_data[8*pick +: 8];
            o_grant     <= ONE_HOT0 << pick;
            o_req_ready <= ONE_HOT0 << pick;
            o_tx_start  <= 1'b1;
            owner       <= pick;
            locked      <= 1'b1;
            last_flag   <= i_req_last[pick];
            state       <= LAUNCH;
          end
        end
        LAUNCH: begin
          o_tx_start  <= 1'b0;
          o_req_ready <= '0;
          cnt         <= '0;
          state       <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (!i_tx_ready) begin
            state <= WAIT_DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
            // The byte is treated as sent on timeout; there is no retry.
            if (cnt == CNT_W'(ACK_TIMEOUT - 1)) begin
              o_err_timeout <= 1'b1;
              state         <= WAIT_DONE;
            end
          end
        end
        WAIT_DONE: begin
          if (i_tx_ready) begin
            if (last_flag) begin
              locked  <= 1'b0;
              ptr     <= next_ptr;
              o_grant <= '0;
            end
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_busy  = (state != IDLE);
  assign o_state = state;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: a round-robin table of single-byte packet
// rounds plus hand-written sequences for latency, packet lock, owner stall,
// acknowledge timeout and reset in the middle of a transfer.
module tb_uart_tx_arbiter;

  localparam int NR      = 4;
  localparam int ACK     = 4;
  localparam int TX_BUSY = 3;

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_LAUNCH    = 2'd1;
  localparam logic [1:0] S_WAIT_DONE = 2'd3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NR-1:0]   req_valid = '0;
  logic [8*NR-1:0] req_data  = '0;
  logic [NR-1:0]   req_last  = '0;
  logic [NR-1:0]   req_ready;
  logic [NR-1:0]   grant;
  logic [7:0]      tx_data;
  logic            tx_start;
  logic            tx_ready = 1'b1;
  logic            busy;
  logic            err_timeout;
  logic [1:0]      state;

  uart_tx_arbiter #(.NUM_REQ(NR), .ACK_TIMEOUT(ACK)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_req_valid  (req_valid),
    .i_req_data   (req_data),
    .i_req_last   (req_last),
    .o_req_ready  (req_ready),
    .o_grant      (grant),
    .o_tx_data    (tx_data),
    .o_tx_start   (tx_start),
    .i_tx_ready   (tx_ready),
    .o_busy       (busy),
    .o_err_timeout(err_timeout),
    .o_state      (state)
  );

  // ---------------- scoreboard state ----------------
  int tests = 0;
  int fails = 0;
  logic [11:0] exp_q[$];          // {grant[3:0], data[7:0]} per expected launch
  logic [8:0]  rq [NR][$];        // per-requester {last, data} byte queues
  bit          tx_auto = 1'b1;    // transmitter model answers launches
  int          tx_busy = 0;
  int          launch_cnt = 0;
  logic [11:0] mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic sync();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input int k, input logic [7:0] d, input logic l);
    rq[k].push_back({l, d});
  endtask

  task automatic expect_launch(input int k, input logic [7:0] d);
    logic [3:0] g;
    g = 4'b0001 << k;
    exp_q.push_back({g, d});
  endtask

  function automatic bit all_rq_empty();
    bit e;
    e = 1'b1;
    for (int k = 0; k < NR; k++) if (rq[k].size() != 0) e = 1'b0;
    return e;
  endfunction

  task automatic wait_drain(input string name, input int budget);
    bit done;
    done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && all_rq_empty() && state == S_IDLE && grant == '0)
        done = 1'b1;
    end
    check({name, "_drained"}, done, 1);
  endtask

  // ---------------- monitor, transmitter and requester models ----------------
  always @(negedge clk) begin
    if (rst) begin
      tx_ready = 1'b1;
      tx_busy  = 0;
    end else begin
      if (tx_start) begin
        launch_cnt++;
        check("start_while_tx_ready", tx_ready, 1);
        if (exp_q.size() == 0) begin
          check("unexpected_launch", {grant, tx_data}, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("launch_grant", grant, mon_e[11:8]);
          check("launch_req_ready", req_ready, mon_e[11:8]);
          check("launch_data", tx_data, mon_e[7:0]);
        end
      end else if (req_ready != '0) begin
        check("req_ready_outside_launch", req_ready, 0);
      end
      // transmitter: drop ready while shifting, for TX_BUSY cycles
      if (tx_busy > 0) begin
        tx_busy--;
        if (tx_busy == 0) tx_ready = 1'b1;
      end else if (tx_auto && tx_start) begin
        tx_ready = 1'b0;
        tx_busy  = TX_BUSY;
      end
      // requesters: consume on accept, then present the queue head
      for (int k = 0; k < NR; k++) begin
        if (req_ready[k] && rq[k].size() > 0) void'(rq[k].pop_front());
        if (rq[k].size() > 0) begin
          req_valid[k]        = 1'b1;
          req_data[8*k +: 8]  = rq[k][0][7:0];
          req_last[k]         = rq[k][0][8];
        end else begin
          req_valid[k]        = 1'b0;
          req_data[8*k +: 8]  = 8'h00;
          req_last[k]         = 1'b0;
        end
      end
    end
  end

  // ---------------- round-robin vector table ----------------
  typedef struct {
    logic [3:0] mask;
    logic [7:0] base;
    int         n;
    int         order[4];
  } rr_vec_t;

  rr_vec_t vecs[6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          l0;
    int          bad;
    int          bad_busy;
    bit          seen;
    logic [7:0]  d;

    // pointer starts at 0 after reset; each row leaves it at owner+1 of the
    // last packet served
    vecs[0] = '{4'b1111, 8'hA0, 4, '{0, 1, 2, 3}};  // ptr 0 -> 0
    vecs[1] = '{4'b0101, 8'hA0, 2, '{0, 2, 0, 0}};  // ptr 0 -> 3
    vecs[2] = '{4'b0011, 8'hB0, 2, '{0, 1, 0, 0}};  // ptr 3 -> 2
    vecs[3] = '{4'b1001, 8'hC0, 2, '{3, 0, 0, 0}};  // ptr 2 -> 1
    vecs[4] = '{4'b1110, 8'hD0, 3, '{1, 2, 3, 0}};  // ptr 1 -> 0
    vecs[5] = '{4'b0100, 8'hE0, 1, '{2, 0, 0, 0}};  // ptr 0 -> 3

    // ---- reset state ----
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_grant", grant, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_tx_start", tx_start, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err_timeout, 0);
    check("rst_state", state, S_IDLE);
    @(posedge clk);
    #2 rst = 1'b0;

    // ---- single byte with latency ----
    sync();
    push(0, 8'h55, 1'b1);
    expect_launch(0, 8'h55);
    @(negedge clk);
    check("t1_no_early_start", tx_start, 0);
    @(negedge clk);
    check("t1_start", tx_start, 1);
    check("t1_data", tx_data, 8'h55);
    check("t1_req_ready", req_ready, 4'b0001);
    check("t1_busy", busy, 1);
    check("t1_state", state, S_LAUNCH);
    wait_drain("t1", 50);
    check("t1_grant_cleared", grant, 0);

    // pointer is now 1: requester 1 wins over requester 0
    sync();
    push(0, 8'hC0, 1'b1);
    push(1, 8'hC1, 1'b1);
    expect_launch(1, 8'hC1);
    expect_launch(0, 8'hC0);
    wait_drain("t1_ptr1", 100);

    // ---- round-robin table, from a fresh pointer ----
    sync();
    rst = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    for (int r = 0; r < 6; r++) begin
      sync();
      for (int k = 0; k < NR; k++) begin
        if (vecs[r].mask[k]) begin
          d = vecs[r].base + 8'(k);
          push(k, d, 1'b1);
        end
      end
      for (int j = 0; j < vecs[r].n; j++) begin
        d = vecs[r].base + 8'(vecs[r].order[j]);
        expect_launch(vecs[r].order[j], d);
      end
      wait_drain($sformatf("rr%0d", r), 200);
    end

    // ---- packet lock: req1 3-byte packet while req2 waits (ptr 3) ----
    sync();
    push(1, 8'h11, 1'b0);
    push(1, 8'h22, 1'b0);
    push(1, 8'h33, 1'b1);
    push(2, 8'h44, 1'b1);
    expect_launch(1, 8'h11);
    expect_launch(1, 8'h22);
    expect_launch(1, 8'h33);
    expect_launch(2, 8'h44);
    l0  = launch_cnt;
    bad = 0;
    for (int c = 0; c < 200 && launch_cnt < l0 + 3; c++) begin
      @(negedge clk);
      if (launch_cnt > l0 && grant != 4'b0010) bad++;
    end
    check("lock_grant_held", bad, 0);
    wait_drain("lock", 200);

    // ---- owner stall: req0 opens a packet then goes quiet (ptr 3) ----
    sync();
    push(0, 8'h5A, 1'b0);
    expect_launch(0, 8'h5A);
    seen = 1'b0;
    for (int c = 0; c < 60 && !seen; c++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && rq[0].size() == 0 && state == S_IDLE) seen = 1'b1;
    end
    check("stall_first_byte_done", seen, 1);
    check("stall_grant_locked", grant, 4'b0001);
    sync();
    push(3, 8'h3C, 1'b1);
    l0       = launch_cnt;
    bad      = 0;
    bad_busy = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy) bad_busy++;
      if (grant != 4'b0001) bad++;
    end
    check("stall_no_start", launch_cnt - l0, 0);
    check("stall_not_busy", bad_busy, 0);
    check("stall_grant_held", bad, 0);
    check("stall_state_idle", state, S_IDLE);
    sync();
    push(0, 8'h5B, 1'b1);
    expect_launch(0, 8'h5B);
    expect_launch(3, 8'h3C);
    wait_drain("stall_resume", 200);

    // ---- acknowledge timeout (ptr 0) ----
    tx_auto = 1'b0;
    sync();
    push(2, 8'h77, 1'b1);
    expect_launch(2, 8'h77);
    seen = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk);
      if (tx_start) seen = 1'b1;
    end
    check("to_launch_seen", seen, 1);
    for (int c = 0; c < ACK; c++) begin
      @(negedge clk);
      check($sformatf("to_err_clear_c%0d", c), err_timeout, 0);
    end
    @(negedge clk);
    check("to_err_set", err_timeout, 1);
    check("to_state_wait_done", state, S_WAIT_DONE);
    tx_auto = 1'b1;
    wait_drain("to_first", 50);
    sync();
    push(1, 8'h66, 1'b1);
    expect_launch(1, 8'h66);
    wait_drain("to_next", 100);
    check("to_err_sticky", err_timeout, 1);

    // ---- reset while in WAIT_DONE (ptr 2) ----
    sync();
    push(3, 8'h99, 1'b1);
    expect_launch(3, 8'h99);
    seen = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk);
      if (state == S_WAIT_DONE) seen = 1'b1;
    end
    check("mr_reached_wait_done", seen, 1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("mr_grant", grant, 0);
    check("mr_req_ready", req_ready, 0);
    check("mr_tx_start", tx_start, 0);
    check("mr_tx_data", tx_data, 0);
    check("mr_busy", busy, 0);
    check("mr_err", err_timeout, 0);
    check("mr_state", state, S_IDLE);
    @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    sync();
    push(3, 8'h98, 1'b1);
    push(0, 8'h01, 1'b1);
    expect_launch(0, 8'h01);
    expect_launch(3, 8'h98);
    wait_drain("mr_after", 200);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
